latency_memory: RTL
===================

Name: latency_memory

Overview:
- Parametrised successor to the single-cycle data memory.
- Word-addressed storage array behind a valid/ready request channel and a valid/ready response channel.
- Programmable access latency, byte-enable writes and out-of-range error reporting.
- Models a slow memory for the multi-cycle CPU datapath and the cache-refill bench; one transaction in flight at a time.

Parameters:
- DATA_W, 32, data word width in bits; must be a multiple of 8.
- ADDR_W, 32, request address width in bits (word address).
- DEPTH_LOG2, 10, log2 of the number of words; array holds 2**DEPTH_LOG2 words.
- LATENCY, 2, cycles from request accept to response valid; legal range 1..15.

Ports:
- clock  input  1  rising-edge clock for all state.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request.
- req_wen  input  1  1 = write, 0 = read.
- req_addr  input  ADDR_W  word address.
- req_wdata  input  DATA_W  write data.
- req_be  input  DATA_W/8  byte enables for writes; ignored on reads.
- resp_valid  output  1  response present.
- resp_ready  input  1  consumer takes response.
- resp_rdata  output  DATA_W  read data; 0 for writes and errors.
- resp_err  output  1  address out of range.

Behaviour:
- Reset: clock is rising-edge; reset is asynchronous, active-low.
  - While reset=0: state=IDLE, req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0, latency counter=0.
  - Array contents are not cleared.
  - A reset asserted mid-transaction drops the transaction; any write not yet performed never happens.
- State machine (IDLE, BUSY, RESP):
  - IDLE: req_ready=1. On an edge with req_valid=1, capture wen/addr/wdata/be, load counter with LATENCY-1, go to BUSY.
  - BUSY: req_ready=0. If counter!=0, decrement. If counter==0, perform the access at this edge and go to RESP.
  - RESP: resp_valid=1, outputs held stable. On an edge with resp_ready=1, clear resp_valid/rdata/err and go to IDLE.
  - A request is never accepted in the RESP-to-IDLE cycle; there is a one-cycle bubble.
- Latency: request accepted at edge N gives resp_valid high after edge N+LATENCY. Best-case throughput is one transaction per LATENCY+2 cycles.
- Address check: index = addr[DEPTH_LOG2-1:0]. Error when addr[ADDR_W-1:DEPTH_LOG2] != 0.
  - On error: resp_err=1, no write, resp_rdata=0.
- Write: for each lane i with be[i]=1, byte i of array[index] = wdata byte i; other bytes are unchanged.
  - be=0 is a legal no-op write with resp_err=0. resp_rdata=0.
- Read: resp_rdata = array[index] sampled at the access edge, including writes completed by earlier transactions.
- Upstream signals:
  - req_* may change freely while req_ready=0; they are not sampled.
  - resp_ready while resp_valid=0 is ignored.
- Unknown req_wen (X) at accept: treat as read and flag resp_err=1 in simulation.

Decomposition:
- Shared package latency_memory_pkg holds:
  - state encoding (IDLE=2'd0, BUSY=2'd1, RESP=2'd2);
  - LATENCY range constants (MIN 1, MAX 15);
  - counter width 4.
- Sub-module mem_array: byte-enabled storage with synchronous write, combinational read, ports (clock, we, be, index, wdata, rdata). The FSM instantiates one copy.

Test Plan:
- Reset then idle, LATENCY=2 -> after reset release req_ready=1, resp_valid=0, resp_rdata=0.
- Write addr=5, wdata=32'hDEADBEEF, be=4'hF accepted at edge N -> resp_valid after edge N+2, resp_err=0.
  - Then read addr=5 -> resp_rdata=32'hDEADBEEF.
- Partial write addr=5, wdata=32'h11223344, be=4'b0101 -> subsequent read returns 32'hDE22BE44.
- Read addr=32'h400 (DEPTH_LOG2=10) -> resp_err=1, resp_rdata=0. Write to 32'h400 leaves array[0] unchanged.
- Hold resp_ready=0 for 5 cycles in RESP -> resp_valid and resp_rdata stable, req_ready=0. Second req_valid is not accepted until the cycle after the resp handshake.
- Assert reset during BUSY of write addr=7 -> array[7] keeps its prior value, outputs go to reset values immediately. With LATENCY=1, the next read responds one edge after accept.

Source files
------------

// File: rtl/latency_memory_pkg.sv
// Shared definitions for the latency_memory block: FSM encoding, latency limits and
// the width of the access-latency counter.
package latency_memory_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StResp = 2'd2
  } state_e;

  localparam int unsigned LatencyMin = 1;
  localparam int unsigned LatencyMax = 15;
  localparam int unsigned CntW       = 4;

endpackage

// File: rtl/latency_memory_mem_array.sv
// Byte-enabled word storage: synchronous write, combinational read, no reset on contents.
module mem_array
  import latency_memory_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic                  clock,
  input  logic                  we,
  input  logic [DATA_W/8-1:0]   be,
  input  logic [DEPTH_LOG2-1:0] index,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clock) begin
    if (we) begin
      for (int i = 0; i < DATA_W / 8; i++) begin
        if (be[i]) begin
          mem[index][i*8 +: 8] <= wdata[i*8 +: 8];
        end
      end
    end
  end

  assign rdata = mem[index];

endmodule

// File: rtl/latency_memory.sv
// Slow word-addressed memory behind valid/ready request and response channels, with a
// programmable access latency, byte-enable writes and out-of-range error reporting.
module latency_memory
  import latency_memory_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned LATENCY    = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_wen,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_err
);

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                wen_q, bad_wen_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] be_q;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic                capture;
  logic                access;
  logic                range_err;
  logic                wen_known;
  logic                arr_we;
  logic [DATA_W-1:0]   arr_rdata;

  // An unknown write-enable only shows up in simulation; it is handled as a flagged read.
  assign wen_known = (req_wen === 1'b0) || (req_wen === 1'b1);

  assign range_err = (addr_q >> DEPTH_LOG2) != '0;
  assign access    = (state_q == StBusy) && (cnt_q == '0);
  assign arr_we    = access && wen_q && !range_err && !bad_wen_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    capture = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          capture = 1'b1;
          cnt_d   = CntW'(LATENCY - 1);
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CntW'(1);
        end else begin
          state_d = StResp;
          err_d   = range_err || bad_wen_q;
          rdata_d = (wen_q || err_d) ? '0 : arr_rdata;
        end
      end
      StResp: begin
        if (resp_ready) begin
          state_d = StIdle;
          rdata_d = '0;
          err_d   = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wen_q     <= 1'b0;
      bad_wen_q <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
    end else if (capture) begin
      wen_q     <= (req_wen === 1'b1);
      bad_wen_q <= !wen_known;
      addr_q    <= req_addr;
      wdata_q   <= req_wdata;
      be_q      <= req_be;
    end
  end

  mem_array #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_mem_array (
    .clock (clock),
    .we    (arr_we),
    .be    (be_q),
    .index (addr_q[DEPTH_LOG2-1:0]),
    .wdata (wdata_q),
    .rdata (arr_rdata)
  );

  // Reset is folded in so the request channel reads not-ready while reset is held.
  assign req_ready  = reset && (state_q == StIdle);
  assign resp_valid = (state_q == StResp);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule
